// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// Operands are registered toward the ALU, and the registered result goes back to the granted port.
module alu_arbiter #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned SELW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [SELW-1:0]  req0_sel,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [SELW-1:0]  req1_sel,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [SELW-1:0]  alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_x
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;
  logic   cur_grant;
  logic   any_valid_c;
  logic   grant1_c;
  logic   accept_c;

  // Lone valid wins; under contention the port not served last time wins.
  always_comb begin
    any_valid_c = req0_valid | req1_valid;
    grant1_c    = req1_valid & (~req0_valid | ~last_grant);
    accept_c    = (state == IDLE) & ~rst & any_valid_c;
  end

  // The accept pulse must coincide with the IDLE cycle that loads the operands.
  assign req0_ready = accept_c & ~grant1_c;
  assign req1_ready = accept_c & grant1_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_grant  <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_data   <= '0;
      alu_sel    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid_c) begin
            cur_grant <= grant1_c;
            alu_sel   <= grant1_c ? req1_sel : req0_sel;
            alu_a     <= grant1_c ? req1_a : req0_a;
            alu_b     <= grant1_c ? req1_b : req0_b;
            busy      <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          rsp_data   <= alu_x;
          rsp0_valid <= ~cur_grant;
          rsp1_valid <= cur_grant;
          state      <= RESP;
        end
        RESP: begin
          // Fairness pointer moves only once the result has been taken.
          if (rsp_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            last_grant <= cur_grant;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
